// File: rtl/execute_stage.sv
// Execute stage of a 5-stage RISC-V pipeline: ID/EX register, operand forwarding,
// ALU, branch resolution and the EX/MEM register.
module execute_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  FlushE,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  ResultSrcD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [REG_ADDR-1:0]   Rs1D,
  input  logic [REG_ADDR-1:0]   Rs2D,
  input  logic [REG_ADDR-1:0]   RdD,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [REG_ADDR-1:0]   Rs1E,
  output logic [REG_ADDR-1:0]   Rs2E,
  output logic [REG_ADDR-1:0]   RdE,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR-1:0]   RdM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCPlus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  result_src;
    logic                  branch;
    logic                  alu_src;
    logic [2:0]            alu_ctl;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR-1:0]   rs1;
    logic [REG_ADDR-1:0]   rs2;
    logic [REG_ADDR-1:0]   rd;
  } idex_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  result_src;
    logic [REG_ADDR-1:0]   rd;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } exmem_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;

  logic [DATA_WIDTH-1:0] src_a_e;
  logic [DATA_WIDTH-1:0] write_data_e;
  logic [DATA_WIDTH-1:0] src_b_e;
  logic [DATA_WIDTH-1:0] alu_result_e;
  logic                  zero_e;

  // Code 11 is unused by the forwarding unit and falls back to the register value.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] reg_val,
    input logic [DATA_WIDTH-1:0] result_w,
    input logic [DATA_WIDTH-1:0] alu_result_m
  );
    case (sel)
      2'b01:   fwd_sel = result_w;
      2'b10:   fwd_sel = alu_result_m;
      default: fwd_sel = reg_val;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu(
    input logic [2:0]            ctl,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    a_s = a;
    b_s = b;
    case (ctl)
      ALU_ADD: alu = a + b;
      ALU_SUB: alu = a - b;
      ALU_AND: alu = a & b;
      ALU_OR:  alu = a | b;
      ALU_SLT: alu = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      default: alu = '0;
    endcase
  endfunction

  // ID/EX: a flush loads a full bubble, data fields included
  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write  = RegWriteD;
      idex_d.mem_write  = MemWriteD;
      idex_d.result_src = ResultSrcD;
      idex_d.branch     = BranchD;
      idex_d.alu_src    = ALUSrcD;
      idex_d.alu_ctl    = ALUControlD;
      idex_d.rd1        = RD1D;
      idex_d.rd2        = RD2D;
      idex_d.pc         = PCD;
      idex_d.pc_plus4   = PCPlus4D;
      idex_d.imm        = ImmExtD;
      idex_d.rs1        = Rs1D;
      idex_d.rs2        = Rs2D;
      idex_d.rd         = RdD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  // Execute: forwarding uses the EX/MEM register as it stands this cycle
  always_comb begin
    src_a_e      = fwd_sel(ForwardAE, idex_q.rd1, ResultW, exmem_q.alu_result);
    write_data_e = fwd_sel(ForwardBE, idex_q.rd2, ResultW, exmem_q.alu_result);
    src_b_e      = idex_q.alu_src ? idex_q.imm : write_data_e;
    alu_result_e = alu(idex_q.alu_ctl, src_a_e, src_b_e);
    zero_e       = (alu_result_e == '0);
  end

  // EX/MEM: captured every cycle, no flush or stall
  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.result_src = idex_q.result_src;
    exmem_d.rd         = idex_q.rd;
    exmem_d.alu_result = alu_result_e;
    exmem_d.write_data = write_data_e;
    exmem_d.pc_plus4   = idex_q.pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign Rs1E       = idex_q.rs1;
  assign Rs2E       = idex_q.rs2;
  assign RdE        = idex_q.rd;
  assign PCSrcE     = idex_q.branch & zero_e;
  assign PCTargetE  = idex_q.pc + idex_q.imm;
  assign RegWriteM  = exmem_q.reg_write;
  assign MemWriteM  = exmem_q.mem_write;
  assign ResultSrcM = exmem_q.result_src;
  assign RdM        = exmem_q.rd;
  assign ALUResultM = exmem_q.alu_result;
  assign WriteDataM = exmem_q.write_data;
  assign PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a stage-level instruction model predicts
// the outputs each cycle; a negedge monitor pops and compares them.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        FlushE;
  logic        RegWriteD, MemWriteD, ResultSrcD, BranchD, ALUSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  execute_stage #(.DATA_WIDTH(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, mw, rs, br, as;
    logic [2:0]  ctl;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    logic [4:0]  rs1e, rs2e, rde;
    logic        pcsrc;
    logic [31:0] pct;
    logic        rwm, mwm, rsm;
    logic [4:0]  rdm;
    logic [31:0] alum, wdm, pc4m;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  // Model state: the instruction sitting in E and the retired fields sitting in M
  instr_t      me;
  logic        m_rw, m_mw, m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                       input logic [31:0] resw, input logic [31:0] alum);
    if (sel == 2'd1) return resw;
    if (sel == 2'd2) return alum;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctl)
      3'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t predict(input logic [1:0] fa, input logic [1:0] fb,
                                   input logic [31:0] resw, output logic [31:0] res,
                                   output logic [31:0] wd);
    exp_t x;
    logic [31:0] a;
    a   = pick(fa, me.rd1, resw, m_alu);
    wd  = pick(fb, me.rd2, resw, m_alu);
    res = ref_alu(me.ctl, a, me.as ? me.imm : wd);
    x.rs1e = me.rs1; x.rs2e = me.rs2; x.rde = me.rd;
    x.pcsrc = me.br && (res == 32'd0);
    x.pct = me.pc + me.imm;
    x.rwm = m_rw; x.mwm = m_mw; x.rsm = m_rs; x.rdm = m_rd;
    x.alum = m_alu; x.wdm = m_wd; x.pc4m = m_pc4;
    return x;
  endfunction

  // Called just after a rising edge: applies inputs, queues this cycle's expectations,
  // then advances the model across the next edge.
  task automatic drive(input instr_t d, input logic fl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] resw);
    logic [31:0] res, wd;
    exp_t x;
    FlushE = fl; RegWriteD = d.rw; MemWriteD = d.mw; ResultSrcD = d.rs; BranchD = d.br;
    ALUSrcD = d.as; ALUControlD = d.ctl; RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc;
    PCPlus4D = d.pc4; ImmExtD = d.imm; Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
    ForwardAE = fa; ForwardBE = fb; ResultW = resw;
    x = predict(fa, fb, resw, res, wd);
    q.push_back(x);
    @(posedge clk); #1;
    m_rw = me.rw; m_mw = me.mw; m_rs = me.rs; m_rd = me.rd;
    m_alu = res; m_wd = wd; m_pc4 = me.pc4;
    me = fl ? '0 : d;
  endtask

  function automatic instr_t rand_instr();
    instr_t d;
    d.rw = 1'($urandom); d.mw = 1'($urandom); d.rs = 1'($urandom);
    d.br = 1'($urandom); d.as = 1'($urandom); d.ctl = 3'($urandom_range(0, 7));
    d.rd1 = $urandom; d.rd2 = ($urandom_range(0, 3) == 0) ? d.rd1 : $urandom;
    d.pc = $urandom; d.pc4 = d.pc + 32'd4; d.imm = $urandom;
    d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
    return d;
  endfunction

  function automatic instr_t alu_instr(input logic [2:0] ctl, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd);
    instr_t d = '0;
    d.ctl = ctl; d.rd1 = a; d.rd2 = b; d.rd = rd; d.rw = 1'b1;
    return d;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " Rs1E"}, 32'(Rs1E), 0);       chk({tag, " Rs2E"}, 32'(Rs2E), 0);
    chk({tag, " RdE"}, 32'(RdE), 0);         chk({tag, " PCSrcE"}, 32'(PCSrcE), 0);
    chk({tag, " PCTargetE"}, PCTargetE, 0);  chk({tag, " RegWriteM"}, 32'(RegWriteM), 0);
    chk({tag, " MemWriteM"}, 32'(MemWriteM), 0);
    chk({tag, " ResultSrcM"}, 32'(ResultSrcM), 0);
    chk({tag, " RdM"}, 32'(RdM), 0);         chk({tag, " ALUResultM"}, ALUResultM, 0);
    chk({tag, " WriteDataM"}, WriteDataM, 0); chk({tag, " PCPlus4M"}, PCPlus4M, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk("Rs1E", 32'(Rs1E), 32'(x.rs1e));        chk("Rs2E", 32'(Rs2E), 32'(x.rs2e));
      chk("RdE", 32'(RdE), 32'(x.rde));           chk("PCSrcE", 32'(PCSrcE), 32'(x.pcsrc));
      chk("PCTargetE", PCTargetE, x.pct);         chk("RegWriteM", 32'(RegWriteM), 32'(x.rwm));
      chk("MemWriteM", 32'(MemWriteM), 32'(x.mwm));
      chk("ResultSrcM", 32'(ResultSrcM), 32'(x.rsm));
      chk("RdM", 32'(RdM), 32'(x.rdm));           chk("ALUResultM", ALUResultM, x.alum);
      chk("WriteDataM", WriteDataM, x.wdm);       chk("PCPlus4M", PCPlus4M, x.pc4m);
    end
  end

  initial begin
    instr_t nop, d;
    logic [31:0] dummy_r, dummy_w;
    nop = '0;
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      d = rand_instr();
      RD1D = d.rd1; RD2D = d.rd2; RdD = d.rd; RegWriteD = 1'b1; PCD = d.pc; ImmExtD = d.imm;
      Rs1D = d.rs1; Rs2D = d.rs2; FlushE = 1'b0; BranchD = 1'b1;
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    me = '0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;

    d = alu_instr(3'd0, 32'd1, 32'd2, 5'd7);
    drive(d, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("first_rde", 32'(RdE), 32'd7);

    // Plain add reaches M after two edges
    drive(alu_instr(3'd0, 32'd5, 32'd7, 5'd3), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("add_alu", ALUResultM, 32'd12); chk("add_rd", 32'(RdM), 32'd3);
    chk("add_rw", 32'(RegWriteM), 32'd1); chk("add_wd", WriteDataM, 32'd7);

    // Forwarding: A from ALUResultM (0x10), B from ResultW (0x20)
    drive(alu_instr(3'd0, 32'h10, 32'd0, 5'd1), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(alu_instr(3'd1, 32'h55, 32'h66, 5'd2), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd2, 2'd1, 32'h20);
    chk("fwd_sub", ALUResultM, 32'hFFFF_FFF0); chk("fwd_wd", WriteDataM, 32'h20);
    drive(alu_instr(3'd0, 32'h3, 32'h4, 5'd2), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd3, 2'd3, 32'h20);
    chk("fwd11", ALUResultM, 32'h7);

    drive(alu_instr(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd5), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("slt_neg", ALUResultM, 32'd1);
    drive(alu_instr(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd5), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("add_wrap", ALUResultM, 32'd0);
    drive(alu_instr(3'd7, 32'h5, 32'h3, 5'd5), 1'b0, 2'd0, 2'd0, 32'd0);
    drive(nop, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("ctl111", ALUResultM, 32'd0);

    d = alu_instr(3'd1, 32'd9, 32'd9, 5'd0);
    d.rw = 1'b0; d.br = 1'b1; d.pc = 32'h100; d.imm = 32'hFFFF_FFF8;
    drive(d, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("br_taken", 32'(PCSrcE), 32'd1); chk("br_target", PCTargetE, 32'hF8);
    d.rd2 = 32'd8;
    drive(d, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("br_not_taken", 32'(PCSrcE), 32'd0);

    // Flush squashes the incoming instruction
    d = alu_instr(3'd0, 32'd1, 32'd1, 5'd4);
    d.mw = 1'b1;
    drive(d, 1'b1, 2'd0, 2'd0, 32'd0);
    chk("flush_rde", 32'(RdE), 32'd0);
    drive(nop, 1'b0, 2'd0, 2'd0, 32'd0);
    chk("flush_rwm", 32'(RegWriteM), 32'd0); chk("flush_mwm", 32'(MemWriteM), 32'd0);
    chk("flush_rdm", 32'(RdM), 32'd0);

    for (int i = 0; i < 300; i++)
      drive(rand_instr(), ($urandom_range(0, 7) == 0), 2'($urandom), 2'($urandom), $urandom);

    // Asynchronous reset mid-cycle with a taken branch in E
    d = alu_instr(3'd1, 32'd9, 32'd9, 5'd6);
    d.br = 1'b1; d.pc = 32'h200; d.imm = 32'h40; d.pc4 = 32'h204;
    drive(d, 1'b0, 2'd0, 2'd0, 32'd0);
    drive(rand_instr(), 1'b0, 2'd0, 2'd0, 32'd0);
    q.push_back(predict(2'd0, 2'd0, 32'd0, dummy_r, dummy_w));
    @(negedge clk); #1;
    FlushE = 1'b1;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_flush_hold");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic drive_idle();
    FlushE = 0; RegWriteD = 0; MemWriteD = 0; ResultSrcD = 0; BranchD = 0; ALUSrcD = 0;
    ALUControlD = 0; RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

endmodule
